lifo_stack_core: RTL and testbench

//  Storage and stack pointer of the LIFO, directly upstream of the LIFO status stage.

---
 rtl/lifo_pkg.sv | 14 +
 rtl/lifo_stack_core_if.sv | 26 ++
 rtl/lifo_stack_core_ram.sv | 21 ++
 rtl/lifo_stack_core.sv | 98 +++++++++
 tb/tb_lifo_stack_core.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/lifo_pkg.sv
// Shared defaults and the per-cycle operation encoding for the LIFO stack core.
package lifo_pkg;
  localparam int LIFO_DATA_W = 8;
  localparam int LIFO_DEPTH  = 16;
  localparam int LIFO_PTR_W  = 10;

  // Encoding is {re, we}, so the decode is a plain bit concatenation.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } lifo_op_e;
endpackage

// File: rtl/lifo_stack_core_if.sv
// Request/response bundle between a LIFO user (master) and lifo_stack_core (slave).
interface lifo_stack_core_if import lifo_pkg::*; #(
  parameter int DATA_W = LIFO_DATA_W,
  parameter int PTR_W  = LIFO_PTR_W
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              lifo_empty;
  logic              lifo_full;
  logic [PTR_W-1:0]  pointer;
  logic [DATA_W-1:0] top_data;
  logic              top_valid;

  modport master (
    output wr, rd, din,
    input  dout, dout_valid, lifo_empty, lifo_full, pointer, top_data, top_valid
  );

  modport slave (
    input  wr, rd, din,
    output dout, dout_valid, lifo_empty, lifo_full, pointer, top_data, top_valid
  );
endinterface

// File: rtl/lifo_stack_core_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module lifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_stack_core.sv
// LIFO stack core: op decode, occupancy pointer, registered flags and pop data.
// Define LIFO_PEEK_EN to build the registered top-of-stack peek output.
module lifo_stack_core import lifo_pkg::*; #(
  parameter int DATA_W = LIFO_DATA_W,
  parameter int DEPTH  = LIFO_DEPTH,
  parameter int PTR_W  = LIFO_PTR_W
)(
  input  logic             clk,
  input  logic             rst_n,
  lifo_stack_core_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     cnt, cnt_nxt;
  logic              empty_q, full_q, dv_q;
  logic [DATA_W-1:0] dout_q, rdata, pop_data;
  logic              we, re, ram_we;
  logic [AW-1:0]     waddr, raddr, top_addr;
  lifo_op_e          op;

  assign we = bus.wr & ~full_q;
  assign re = bus.rd & ~empty_q;
  assign op = lifo_op_e'({re, we});

  always_comb begin
    cnt_nxt = cnt;
    case (op)
      OP_PUSH: cnt_nxt = cnt + CW'(1);
      OP_POP:  cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Low-bit arithmetic wraps DEPTH to DEPTH-1 correctly when full.
  assign top_addr = cnt[AW-1:0] - AW'(1);
  assign waddr    = (op == OP_SWAP) ? top_addr : cnt[AW-1:0];
  assign ram_we   = rst_n & we;

  lifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef LIFO_PEEK_EN
  logic [DATA_W-1:0] top_q;
  logic              topv_q;

  // The read port pre-fetches the post-op top; pops are served from top_q.
  assign raddr    = cnt_nxt[AW-1:0] - AW'(1);
  assign pop_data = top_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_q  <= '0;
      topv_q <= 1'b0;
    end else begin
      topv_q <= (cnt_nxt != '0);
      if (we)      top_q <= bus.din;
      else if (re) top_q <= rdata;
    end
  end

  assign bus.top_data  = top_q;
  assign bus.top_valid = topv_q;
`else
  assign raddr         = top_addr;
  assign pop_data      = rdata;
  assign bus.top_data  = '0;
  assign bus.top_valid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == CW'(DEPTH));
      dv_q    <= re;
      if (re) dout_q <= pop_data;
    end
  end

  assign bus.pointer    = PTR_W'(cnt);
  assign bus.lifo_empty = empty_q;
  assign bus.lifo_full  = full_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
endmodule

// File: tb/tb_lifo_stack_core.sv
// Self-checking bench for lifo_stack_core: vector table, corner sequences, random vs queue model.
module tb_lifo_stack_core;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lifo_stack_core_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

  lifo_stack_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         ptr;
    logic       dv;
    logic [7:0] dout;
    logic       empty;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the stack is a queue, back of queue is top of stack.
  logic [7:0] stk[$];
  logic [7:0] m_dout;
  logic       m_dv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pointer", 32'(bus.pointer), 32'(stk.size()));
    check("lifo_empty", 32'(bus.lifo_empty), 32'(stk.size() == 0));
    check("lifo_full", 32'(bus.lifo_full), 32'(stk.size() == DEPTH));
    check("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    check("dout", 32'(bus.dout), 32'(m_dout));
`ifdef LIFO_PEEK_EN
    check("top_valid", 32'(bus.top_valid), 32'(stk.size() != 0));
    if (stk.size() != 0) check("top_data", 32'(bus.top_data), 32'(stk[stk.size()-1]));
`else
    check("top_valid", 32'(bus.top_valid), 32'd0);
    check("top_data", 32'(bus.top_data), 32'd0);
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit mwe, mre;
    bus.wr = w; bus.rd = r; bus.din = d;
    mwe  = w && (stk.size() < DEPTH);
    mre  = r && (stk.size() > 0);
    m_dv = mre;
    if (mre) m_dout = stk[stk.size()-1];
    if (mre && mwe)  stk[stk.size()-1] = d;
    else if (mre)    void'(stk.pop_back());
    else if (mwe)    stk.push_back(d);
    @(posedge clk); #1;
    check_all();
  endtask

  // Reset with garbage on the request lines; w selects whether wr is X or a live push.
  task automatic do_reset(input logic w);
    rst_n = 1'b0; bus.wr = w; bus.rd = 'x; bus.din = 'x;
    @(posedge clk); #1;
    stk.delete(); m_dout = '0; m_dv = 1'b0;
    check_all();
    rst_n = 1'b1; bus.wr = 1'b0; bus.rd = 1'b0; bus.din = '0;
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h33, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h22, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h11, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h11, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h01, 1, 1'b0, 8'h11, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h02, 2, 1'b0, 8'h11, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h55, 2, 1'b1, 8'h02, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'h55, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h01, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 8'h77, 1, 1'b0, 8'h01, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h77, 1'b1};

    rst_n = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.din = '0;
    m_dout = '0; m_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'bx);

    // Idle after reset.
    repeat (3) step(1'b0, 1'b0, 8'h00);
    check("idle_ptr", 32'(bus.pointer), 32'd0);
    check("idle_empty", 32'(bus.lifo_empty), 32'd1);

    // Vector table: push/pop order, swap, empty wr&rd.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      check($sformatf("tbl%0d_ptr", i), 32'(bus.pointer), 32'(tbl[i].ptr));
      check($sformatf("tbl%0d_dv", i), 32'(bus.dout_valid), 32'(tbl[i].dv));
      check($sformatf("tbl%0d_dout", i), 32'(bus.dout), 32'(tbl[i].dout));
      check($sformatf("tbl%0d_empty", i), 32'(bus.lifo_empty), 32'(tbl[i].empty));
    end

    // Fill to full, push while full, pop, then wr&rd while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(bus.lifo_full), 32'd1);
    check("fill_ptr", 32'(bus.pointer), 32'd16);
    step(1'b1, 1'b0, 8'hAA);
    check("ovf_ptr", 32'(bus.pointer), 32'd16);
    step(1'b0, 1'b1, 8'h00);
    check("pop_full_dout", 32'(bus.dout), 32'h0F);
    check("pop_full_ptr", 32'(bus.pointer), 32'd15);
    step(1'b1, 1'b0, 8'h0F);
    step(1'b1, 1'b1, 8'hEE);
    check("full_wrrd_ptr", 32'(bus.pointer), 32'd15);
    check("full_wrrd_dout", 32'(bus.dout), 32'h0F);
    check("full_wrrd_dv", 32'(bus.dout_valid), 32'd1);

    // Reset mid-operation with a live push request.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
    check("pre_rst_ptr", 32'(bus.pointer), 32'd5);
    do_reset(1'b1);
    check("rst_ptr", 32'(bus.pointer), 32'd0);
    check("rst_empty", 32'(bus.lifo_empty), 32'd1);
    step(1'b1, 1'b0, 8'h9C);
`ifdef LIFO_PEEK_EN
    check("peek_after_push", 32'(bus.top_data), 32'h9C);
`endif

    // Random traffic with alternating push/pop bias so both boundaries are hit.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = ((i / 250) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
             8'($urandom_range(0, 255)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
